event_packetizer: RTL
=====================

# event_packetizer

Downstream consumer of the level-1 pixel group arbiter and the top-level arbiter: for each granted pixel it composes the full sensor address from the group address and the in-group pixel address, stamps it with a free-running timestamp and buffers the result as a packet in a small FIFO for the readout interface. It also emits timestamp-wrap marker packets so that absolute time can be reconstructed. It applies backpressure to the arbiter tree through `hold_o` and accounts for every event it drops.

## Interface
- `GRP_ADD`, 2: width of top-level group row/column address
- `PIX_ADD`, 2: width of in-group pixel row/column address (equals `Lvl1_ADD`)
- `TS_W`, 16: timestamp counter width
- `FIFO_DEPTH`, 8: packet FIFO entries (power of two, ≥4)
- `AFULL_TH`, 2: `hold_o` asserts when free entries ≤ this value
- `clk_i` in 1: clock
- `reset_i` in 1: **synchronous, active-low** reset
- `tick_i` in 1: timestamp increment strobe
- `evt_valid_i` in 1: one-cycle strobe, granted pixel address valid
- `grp_x_i` / `grp_y_i` in `GRP_ADD`: group row/column from top level
- `pix_x_i` / `pix_y_i` in `PIX_ADD`: pixel row/column (`x_add_o`/`y_add_o` of level 1)
- `polarity_i` in 1: event polarity
- `pkt_o` out `PKT_W`: head packet, `PKT_W = 2 + 2*(GRP_ADD+PIX_ADD) + TS_W`, fields MSB→LSB `{type, polarity, x, y, ts}`
- `pkt_valid_o` out 1: head packet valid
- `pkt_ready_i` in 1: consumer accepts head
- `hold_o` out 1: stall request to arbiter enable
- `fill_o` out `$clog2(FIFO_DEPTH)+1`: current occupancy
- `drop_cnt_o` out 8: saturating dropped-event count
- `ts_lost_o` out 1: sticky, a wrap marker was lost

## Operation
- Address: `x = {grp_x_i, pix_x_i}`, `y = {grp_y_i, pix_y_i}`, captured in the cycle `evt_valid_i` is high.
- Timestamp `ts` increments by 1 on `tick_i`, wrapping from `2^TS_W-1` to 0. An event takes the `ts` value present in its cycle, before any increment.
- Wrap: the `tick_i` cycle with `ts == 2^TS_W-1` raises a wrap request. A WRAP packet (`type=1`, `polarity/x/y=0`, `ts=0`) is written in that same cycle.
- EVENT packet: `type=0`.
- FIFO accepts up to two writes per cycle. When WRAP and EVENT coincide, WRAP is written first, so it is older than the EVENT.
- Space counts a same-cycle read: `free = FIFO_DEPTH - fill + (pkt_valid_o & pkt_ready_i)`.
- Space allocation: WRAP has priority.
  - `free ≥ need`: all writes are made.
  - `free == 1` with both writes pending: WRAP is written, EVENT is dropped.
  - `free == 0`: everything is dropped.
- Each dropped EVENT increments `drop_cnt_o`, which saturates at 255. A dropped WRAP sets `ts_lost_o`.
- `drop_cnt_o` and `ts_lost_o` clear only on reset.
- Read: the head is presented show-ahead. It pops on `pkt_valid_o & pkt_ready_i`. `pkt_o` is stable while valid and not accepted.

## Timing
- Reset values (`reset_i` low at a clock edge):
  - zero: `ts`, FIFO pointers, `fill_o`, `pkt_valid_o`, `pkt_o`, `hold_o`, `drop_cnt_o`, `ts_lost_o`.
  - Reset mid-operation discards FIFO contents and any pending wrap.
- Latency: event at cycle N gives `pkt_valid_o` high at N+1 if the FIFO was empty. No combinational input→output path.
- `hold_o` is registered from post-update `free ≤ AFULL_TH`, so it lags by 1 cycle. The arbiter tree tolerates ≤2 further events, so `AFULL_TH ≥ 2`.
- `fill_o` is registered post-update.
- A full FIFO with a simultaneous pop accepts one write the same cycle.

## Structure
- Shared package: `PKT_EVENT`/`PKT_WRAP` constants, packet field typedef, `PKT_W` derivation from `GRP_ADD`/`PIX_ADD`/`TS_W`.
- Sub-module `event_fifo`: 2-write/1-read show-ahead FIFO with occupancy and free-count outputs.
- Top level holds the timestamp counter, packet composition, drop/priority logic and counters.

## Test plan
- Single event, grp=(1,2), pix=(3,0), pol=1, ts=5, `pkt_ready_i=1` → packet at N+1: type 0, x=0b0111, y=0b1000, ts=5, then empty.
- `TS_W=4`, 16 ticks with an event on the 16th tick at ts=15 → FIFO order WRAP(ts 0) then EVENT(ts 15); next event stamps ts=0.
- `pkt_ready_i=0`, 10 back-to-back events, depth 8 → 8 stored, `drop_cnt_o=2`, `hold_o` high from the cycle after fill reaches 6.
- FIFO full, `pkt_ready_i=1`, event arrives → one pop and one write same cycle; fill stays 8, no drop.
- Full FIFO, wrap and event coincide with no pop → `ts_lost_o=1`, `drop_cnt_o`+1; with `fill=7`, WRAP is written and the EVENT is dropped.
- `reset_i` low mid-burst with 5 entries → next cycle all outputs zero; following event emerges with the correct ts relative to the restarted counter.

Source files
------------

// File: rtl/event_packetizer_pkg.sv
// Shared packet definitions for the event packetizer: packet type codes,
// default field layout and the packet width derivation.
package event_packetizer_pkg;

    // Packet type field values (MSB of every packet)
    localparam logic PKT_EVENT = 1'b0;
    localparam logic PKT_WRAP  = 1'b1;

    // Default geometry, matching the top-level parameter defaults
    localparam int DEF_GRP_ADD = 2;
    localparam int DEF_PIX_ADD = 2;
    localparam int DEF_TS_W    = 16;

    // Field view of a packet at the default geometry, MSB to LSB
    typedef struct packed {
        logic                                 pkt_type;
        logic                                 polarity;
        logic [DEF_GRP_ADD+DEF_PIX_ADD-1:0]   x;
        logic [DEF_GRP_ADD+DEF_PIX_ADD-1:0]   y;
        logic [DEF_TS_W-1:0]                  ts;
    } pkt_fields_t;

    // Packet width: type + polarity + full x/y addresses + timestamp
    function automatic int pkt_width(input int grp_add, input int pix_add, input int ts_w);
        return 2 + 2 * (grp_add + pix_add) + ts_w;
    endfunction

endpackage

// File: rtl/event_packetizer_fifo.sv
// Two-write / one-read show-ahead FIFO. Port 0 is written before port 1,
// so a same-cycle port-0 entry is older. Head, valid and occupancy are
// registered; the free count includes a same-cycle pop so the writer can
// refill a full FIFO in the cycle it drains.
module event_fifo
    import event_packetizer_pkg::*;
#(
    parameter  int W     = 14,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          wr0_en_i,
    input  logic [W-1:0]  wr0_data_i,
    input  logic          wr1_en_i,
    input  logic [W-1:0]  wr1_data_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  head_o,
    output logic          head_valid_o,
    output logic [CW-1:0] fill_o,
    output logic [CW-1:0] fill_next_o,
    output logic [CW-1:0] free_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr1_idx_s;
    logic [CW-1:0] fill_q, fill_d;
    logic [W-1:0]  head_q, head_d;
    logic          head_valid_q, head_valid_d;
    logic          rd_fire_s;

    // Next-state: storage update, pointer advance and registered head lookahead
    always_comb begin
        rd_fire_s = rd_en_i & head_valid_q;
        wr1_idx_s = wr_ptr_q + AW'(wr0_en_i);
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (wr0_en_i && (wr_ptr_q  == AW'(i))) ? wr0_data_i :
                       (wr1_en_i && (wr1_idx_s == AW'(i))) ? wr1_data_i :
                                                             mem_q[i];
        end
        wr_ptr_d     = wr_ptr_q + AW'(wr0_en_i) + AW'(wr1_en_i);
        rd_ptr_d     = rd_ptr_q + AW'(rd_fire_s);
        fill_d       = fill_q + CW'(wr0_en_i) + CW'(wr1_en_i) - CW'(rd_fire_s);
        head_valid_d = (fill_d != CW'(0));
        head_d       = head_valid_d ? mem_d[rd_ptr_d] : W'(0);
        free_o       = CW'(DEPTH) - fill_q + CW'(rd_fire_s);
        fill_next_o  = fill_d;
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr_q     <= AW'(0);
            rd_ptr_q     <= AW'(0);
            fill_q       <= CW'(0);
            head_q       <= W'(0);
            head_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
        end
    end

    // Packet storage; contents are only observed through valid pointers
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign head_o       = head_q;
    assign head_valid_o = head_valid_q;
    assign fill_o       = fill_q;

endmodule

// File: rtl/event_packetizer.sv
// Event packetizer: stamps granted pixel addresses with a free-running
// timestamp, inserts timestamp-wrap markers, buffers packets in a small
// FIFO, raises backpressure and accounts for every lost event or marker.
module event_packetizer
    import event_packetizer_pkg::*;
#(
    parameter  int GRP_ADD    = 2,
    parameter  int PIX_ADD    = 2,
    parameter  int TS_W       = 16,
    parameter  int FIFO_DEPTH = 8,
    parameter  int AFULL_TH   = 2,
    localparam int PKT_W      = pkt_width(GRP_ADD, PIX_ADD, TS_W),
    localparam int FW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               tick_i,
    input  logic               evt_valid_i,
    input  logic [GRP_ADD-1:0] grp_x_i,
    input  logic [GRP_ADD-1:0] grp_y_i,
    input  logic [PIX_ADD-1:0] pix_x_i,
    input  logic [PIX_ADD-1:0] pix_y_i,
    input  logic               polarity_i,
    output logic [PKT_W-1:0]   pkt_o,
    output logic               pkt_valid_o,
    input  logic               pkt_ready_i,
    output logic               hold_o,
    output logic [FW-1:0]      fill_o,
    output logic [7:0]         drop_cnt_o,
    output logic               ts_lost_o
);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             ts_lost_q, ts_lost_d;
    logic             hold_q, hold_d;

    logic             wrap_req_s;
    logic             wr_wrap_s, wr_evt_s;
    logic             drop_evt_s, drop_wrap_s;
    logic [PKT_W-1:0] evt_pkt_s, wrap_pkt_s;
    logic [FW-1:0]    free_s, fill_next_s;
    logic             rd_en_s;

    // Timestamp, packet composition, space allocation and drop accounting
    always_comb begin
        wrap_req_s  = tick_i & (ts_q == {TS_W{1'b1}});
        ts_d        = tick_i ? (ts_q + TS_W'(1)) : ts_q;

        evt_pkt_s   = {PKT_EVENT, polarity_i, grp_x_i, pix_x_i, grp_y_i, pix_y_i, ts_q};
        wrap_pkt_s  = {PKT_WRAP, (PKT_W-1)'(0)};

        rd_en_s     = pkt_valid_o & pkt_ready_i;

        // The marker claims space first; the event needs a slot beyond it
        wr_wrap_s   = wrap_req_s & (free_s >= FW'(1));
        wr_evt_s    = evt_valid_i & (free_s >= (FW'(1) + FW'(wrap_req_s)));
        drop_wrap_s = wrap_req_s & ~wr_wrap_s;
        drop_evt_s  = evt_valid_i & ~wr_evt_s;

        if (drop_evt_s && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        ts_lost_d = ts_lost_q | drop_wrap_s;

        // Backpressure reflects the space left after this cycle's traffic
        hold_d = ((FW'(FIFO_DEPTH) - fill_next_s) <= FW'(AFULL_TH));
    end

    // Counter and status registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            ts_q       <= TS_W'(0);
            drop_cnt_q <= 8'd0;
            ts_lost_q  <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            drop_cnt_q <= drop_cnt_d;
            ts_lost_q  <= ts_lost_d;
            hold_q     <= hold_d;
        end
    end

    event_fifo #(
        .W     (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .wr0_en_i     (wr_wrap_s),
        .wr0_data_i   (wrap_pkt_s),
        .wr1_en_i     (wr_evt_s),
        .wr1_data_i   (evt_pkt_s),
        .rd_en_i      (rd_en_s),
        .head_o       (pkt_o),
        .head_valid_o (pkt_valid_o),
        .fill_o       (fill_o),
        .fill_next_o  (fill_next_s),
        .free_o       (free_s)
    );

    assign hold_o     = hold_q;
    assign drop_cnt_o = drop_cnt_q;
    assign ts_lost_o  = ts_lost_q;

endmodule
